// File: rtl/bus_dma_if.sv
// Pipelined bus bundle between bus_dma (master) and a memory-side slave.
interface bus_dma_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] data_m2s;
  logic [31:0] data_s2m;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, data_m2s,
    input  data_s2m, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, data_m2s,
    output data_s2m, ack, err, stall
  );
endinterface

// File: rtl/bus_dma.sv
// Chunked memory-to-memory copy engine on a pipelined bus: read a chunk into a FIFO, then write it.
// Optional ack watchdog is compiled in when BUS_DMA_TIMEOUT_EN is defined.
module bus_dma #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        error,
  bus_dma_if.master   bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT == 0)
  begin : g_bad_params
    $error("bus_dma: unsupported FIFO_DEPTH/TIMEOUT");
  end

  typedef enum logic [2:0] {
    StIdle, StRead, StRdrain, StGap, StWrite, StWdrain, StFinish
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   src_q, src_d, dst_q, dst_d;
  logic [15:0]   rem_q, rem_d;
  logic [CW-1:0] chunk_q, chunk_d, left_q, left_d, outs_q, outs_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          wr_phase_q, wr_phase_d;
  logic          error_q, error_d;
  logic [31:0]   mem [FIFO_DEPTH];

  logic          on_bus, stb, issue, ack_ok, push, abort, wd_fire;
  logic [15:0]   rem_src;
  logic [CW-1:0] chunk_sz;

  assign on_bus = (state_q == StRead) || (state_q == StRdrain) ||
                  (state_q == StWrite) || (state_q == StWdrain);
  assign stb    = (state_q == StRead) || (state_q == StWrite);
  assign issue  = stb && !bus.stall;
  // Stray acks (nothing outstanding, or after an abort) are dropped here.
  assign ack_ok = on_bus && bus.ack && (outs_q != '0);
  assign push   = ack_ok && ((state_q == StRead) || (state_q == StRdrain));
  assign abort  = on_bus && (bus.err || wd_fire);

  assign rem_src  = (state_q == StIdle) ? len : rem_q;
  assign chunk_sz = (rem_src >= 16'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH) : CW'(rem_src);

`ifdef BUS_DMA_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;

  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if (on_bus && (outs_q != '0) && !bus.ack) begin
      if (wd_q == WW'(TIMEOUT - 1)) begin
        wd_fire = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    bus.cyc      = on_bus;
    bus.stb      = stb;
    bus.we       = (state_q == StWrite) || (state_q == StWdrain);
    bus.sel      = stb ? 4'hF : 4'h0;
    bus.adr      = (state_q == StRead) ? src_q : (state_q == StWrite) ? dst_q : '0;
    bus.data_m2s = (state_q == StWrite) ? mem[rptr_q] : '0;
  end

  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StFinish);
  assign error = error_q;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    chunk_d    = chunk_q;
    left_d     = left_q;
    wr_phase_d = wr_phase_q;
    error_d    = error_q;
    outs_d     = outs_q + CW'(issue) - CW'(ack_ok);
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = rptr_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          error_d    = 1'b0;
          src_d      = src_addr;
          dst_d      = dst_addr;
          outs_d     = '0;
          wptr_d     = '0;
          rptr_d     = '0;
          wr_phase_d = 1'b0;
          rem_d      = '0;
          if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
            error_d = 1'b1;
            state_d = StFinish;
          end else if (len == 16'd0) begin
            state_d = StFinish;
          end else begin
            chunk_d = chunk_sz;
            left_d  = chunk_sz;
            rem_d   = len - 16'(chunk_sz);
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (issue) begin
          src_d  = src_q + 32'd4;
          left_d = left_q - 1'b1;
          if (left_q == CW'(1)) state_d = StRdrain;
        end
      end
      StRdrain: begin
        if (outs_d == '0) begin
          wr_phase_d = 1'b1;
          state_d    = StGap;
        end
      end
      StGap: begin
        if (wr_phase_q) begin
          left_d  = chunk_q;
          state_d = StWrite;
        end else begin
          chunk_d = chunk_sz;
          left_d  = chunk_sz;
          rem_d   = rem_q - 16'(chunk_sz);
          state_d = StRead;
        end
      end
      StWrite: begin
        if (issue) begin
          dst_d  = dst_q + 32'd4;
          rptr_d = rptr_q + 1'b1;
          left_d = left_q - 1'b1;
          if (left_q == CW'(1)) state_d = StWdrain;
        end
      end
      StWdrain: begin
        if (outs_d == '0) begin
          if (rem_q == 16'd0) begin
            state_d = StFinish;
          end else begin
            wr_phase_d = 1'b0;
            state_d    = StGap;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StFinish;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      left_q     <= '0;
      outs_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      wr_phase_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      chunk_q    <= chunk_d;
      left_q     <= left_d;
      outs_q     <= outs_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wr_phase_q <= wr_phase_d;
      error_q    <= error_d;
    end
  end

  // Storage is only read after being written in the same chunk, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= bus.data_s2m;
  end

endmodule

// File: tb/tb_bus_dma.sv
// Directed + randomized bench for bus_dma against a RAM slave and a word-copy reference model.
module tb_bus_dma;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, error;

  bus_dma_if bus ();

  bus_dma #(.FIFO_DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Written only by the main sequence.
  int          stall_pct = 0;
  bit          noack     = 1'b0;
  int          err_idx   = 0;
  int          clr_req   = 0;
  logic [31:0] before_mem [256];

  // Written only by the slave/monitor process.
  logic [31:0] ram [256];
  bit          filled    = 1'b0;
  int          clr_ack   = 0;
  bit          pend_v    = 1'b0;
  bit          pend_we   = 1'b0;
  logic [31:0] pend_data = '0;
  bit          err_prev  = 1'b0;
  bit          err_seen  = 1'b0;
  logic        cyc_after_err = 1'b1;
  int          wr_acks = 0, n_rd = 0, n_wr = 0, done_cnt = 0;
  bit          cyc_seen = 1'b0, had_cyc = 1'b0, prev_cyc = 1'b0;
  int          run_len = 0, run_iss = 0, low_len = 0;
  int          runs_len[$], runs_iss[$], gaps[$];

  // RAM slave with one-cycle acks plus bus activity monitor; runs mid-cycle.
  always @(negedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 256; i++) ram[i] = $urandom;
      filled = 1'b1;
    end
    if (clr_ack != clr_req) begin
      clr_ack = clr_req;
      wr_acks = 0; n_rd = 0; n_wr = 0; done_cnt = 0;
      cyc_seen = 1'b0; had_cyc = 1'b0; prev_cyc = 1'b0;
      run_len = 0; run_iss = 0; low_len = 0;
      runs_len.delete(); runs_iss.delete(); gaps.delete();
      err_seen = 1'b0; cyc_after_err = 1'b1;
    end
    if (err_prev) begin
      cyc_after_err = bus.cyc;
      err_seen      = 1'b1;
    end
    err_prev     = 1'b0;
    bus.ack      = 1'b0;
    bus.err      = 1'b0;
    bus.data_s2m = '0;
    if (pend_v && !noack) begin
      if (pend_we) begin
        wr_acks++;
        if (wr_acks == err_idx) begin
          bus.err  = 1'b1;
          err_prev = 1'b1;
        end else begin
          bus.ack = 1'b1;
        end
      end else begin
        bus.ack      = 1'b1;
        bus.data_s2m = pend_data;
      end
    end
    bus.stall = (stall_pct > 0) && (int'($urandom_range(99)) < stall_pct);
    pend_v    = bus.cyc && bus.stb && !bus.stall;
    if (pend_v) begin
      pend_we = bus.we;
      if (bus.we) begin
        ram[bus.adr[9:2]] = bus.data_m2s;
        n_wr++;
      end else begin
        pend_data = ram[bus.adr[9:2]];
        n_rd++;
      end
    end
    if (done) done_cnt++;
    if (bus.cyc) begin
      cyc_seen = 1'b1;
      if (!prev_cyc && had_cyc) gaps.push_back(low_len);
      had_cyc = 1'b1;
      run_len++;
      if (pend_v) run_iss++;
    end else begin
      if (prev_cyc) begin
        runs_len.push_back(run_len);
        runs_iss.push_back(run_iss);
        run_len = 0;
        run_iss = 0;
        low_len = 0;
      end
      low_len++;
    end
    prev_cyc = bus.cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    before_mem = ram;
    clr_req++;
    tick(1);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cyc"}, bus.cyc, 1'b0);
    chk({tag, "_stb"}, bus.stb, 1'b0);
    chk({tag, "_we"}, bus.we, 1'b0);
    chk({tag, "_sel"}, bus.sel, 4'h0);
    chk({tag, "_adr"}, bus.adr, 32'h0);
    chk({tag, "_dat"}, bus.data_m2s, 32'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  // Reference: destination words become the source words; chunks of min(rem, DEPTH).
  task automatic check_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int l, input bit nostall);
    logic [31:0] e [256];
    int exp_q[$];
    int bad = 0;
    int rem = l;
    e = before_mem;
    for (int i = 0; i < l; i++) e[((d >> 2) + i) & 255] = before_mem[((s >> 2) + i) & 255];
    for (int i = 0; i < 256; i++) if (ram[i] !== e[i]) bad++;
    chk({tag, "_mem"}, bad, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_reads"}, n_rd, l);
    chk({tag, "_writes"}, n_wr, l);
    while (rem > 0) begin
      int c = (rem < int'(DEPTH)) ? rem : int'(DEPTH);
      exp_q.push_back(c);
      exp_q.push_back(c);
      rem -= c;
    end
    chk({tag, "_phases"}, runs_iss.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= runs_iss.size()) bad++;
      else begin
        if (runs_iss[i] != exp_q[i]) bad++;
        if (nostall && runs_len[i] != exp_q[i] + 1) bad++;
      end
    end
    chk({tag, "_chunks"}, bad, 0);
    chk({tag, "_gap_cnt"}, gaps.size(), exp_q.size() - 1);
    bad = 0;
    foreach (gaps[i]) if (gaps[i] != 1) bad++;
    chk({tag, "_gap_len"}, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    tick(3);
    chk_quiet("reset");
    rst = 1'b0;
    tick(2);

    kick(32'h000, 32'h100, 16'd5);
    wait_idle("single", 200);
    check_copy("single", 32'h000, 32'h100, 5, 1'b1);

    stall_pct = 50;
    kick(32'h040, 32'h300, 16'd20);
    wait_idle("multi", 2000);
    check_copy("multi", 32'h040, 32'h300, 20, 1'b0);
    stall_pct = 0;

    kick(32'hFFFF_FFF8, 32'h080, 16'd3);
    wait_idle("wrap", 200);
    check_copy("wrap", 32'hFFFF_FFF8, 32'h080, 3, 1'b1);

    for (int k = 0; k < 4; k++) begin
      logic [31:0] s, d;
      int l;
      stall_pct = $urandom_range(60);
      l = $urandom_range(24, 1);
      s = 32'($urandom_range(63)) << 2;
      d = 32'h200 + (32'($urandom_range(63)) << 2);
      kick(s, d, 16'(l));
      wait_idle("rand", 2000);
      check_copy("rand", s, d, l, stall_pct == 0);
    end
    stall_pct = 0;

    err_idx = 3;
    kick(32'h000, 32'h200, 16'd8);
    wait_idle("abort", 200);
    chk("abort_err_seen", err_seen, 1'b1);
    chk("abort_cyc_next", cyc_after_err, 1'b0);
    chk("abort_error", error, 1'b1);
    chk("abort_writes", n_wr, 4);
    tick(5);
    chk("abort_done_cnt", done_cnt, 1);
    chk("abort_stays_idle", busy, 1'b0);
    err_idx = 0;

    kick(32'h000, 32'h100, 16'd0);
    chk("len0_done", done, 1'b1);
    chk("len0_error_cleared", error, 1'b0);
    tick(1);
    chk("len0_done_drop", done, 1'b0);
    chk("len0_busy", busy, 1'b0);
    chk("len0_no_cyc", cyc_seen, 1'b0);

    kick(32'h002, 32'h100, 16'd4);
    wait_idle("misal", 10);
    chk("misal_error", error, 1'b1);
    chk("misal_no_cyc", cyc_seen, 1'b0);
    chk("misal_done_cnt", done_cnt, 1);

    kick(32'h000, 32'h100, 16'd20);
    tick(4);
    src_addr = 32'h080; dst_addr = 32'h380; len = 16'd3; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle("busy_start", 500);
    check_copy("busy_start", 32'h000, 32'h100, 20, 1'b1);
    tick(3);
    chk("busy_start_ignored", busy, 1'b0);

    noack = 1'b1;
    kick(32'h000, 32'h100, 16'd4);
    tick(10);
    chk("noack_busy_early", busy, 1'b1);
`ifdef BUS_DMA_TIMEOUT_EN
    wait_idle("wdog", 40);
    chk("wdog_error", error, 1'b1);
    chk("wdog_done_cnt", done_cnt, 1);
`else
    tick(300);
    chk("noack_busy_held", busy, 1'b1);
    chk("noack_no_error", error, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
`endif
    noack = 1'b0;
    tick(2);

    kick(32'h000, 32'h100, 16'd8);
    tick(2);
    chk("pre_rst_cyc", bus.cyc, 1'b1);
    rst = 1'b1;
    tick(1);
    chk_quiet("mid_rst");
    rst = 1'b0;
    tick(3);
    chk("mid_rst_no_done", done_cnt, 0);
    kick(32'h010, 32'h200, 16'd1);
    wait_idle("after_rst", 100);
    check_copy("after_rst", 32'h010, 32'h200, 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
